// File: rtl/dsp_sched_pkg.sv
// dsp_sched_pkg
//   Shared types and constants for the DSP chain scheduler.
//   state_t      : scheduler FSM states
//   MODE_*       : DSP mode encodings (MODE_X is illegal)
//   lat()        : DSP result latency (dsp_start to compare_res) per mode
//   lane_dly()   : operand-lane delay behind dsp_start per mode
package dsp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_RESP
  } state_t;

  localparam logic [1:0] MODE_S = 2'b00;
  localparam logic [1:0] MODE_M = 2'b01;
  localparam logic [1:0] MODE_F = 2'b10;
  localparam logic [1:0] MODE_X = 2'b11;

  function automatic logic [1:0] lat(input logic [1:0] mode);
    case (mode)
      MODE_M:  lat = 2'd1;
      MODE_F:  lat = 2'd3;
      default: lat = 2'd0;
    endcase
  endfunction

  // Mode 10 wants its operands three cycles after the start strobe.
  function automatic logic [1:0] lane_dly(input logic [1:0] mode);
    lane_dly = (mode == MODE_F) ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/dsp_chain_scheduler_lane.sv
// dsp_lane_delay
//   0..3 cycle shift register for the DSP operand lane.
//   clk, rst : clock, async active-high reset
//   sel_i    : delay in cycles (0 = combinational pass-through)
//   d_i      : lane word in
//   q_o      : lane word delayed by sel_i cycles
module dsp_lane_delay #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   sel_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [3:1][W-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[1] <= d_i;
      stage_q[2] <= stage_q[1];
      stage_q[3] <= stage_q[2];
    end
  end

  always_comb begin
    q_o = d_i;
    case (sel_i)
      2'd1:    q_o = stage_q[1];
      2'd2:    q_o = stage_q[2];
      2'd3:    q_o = stage_q[3];
      default: q_o = d_i;
    endcase
  end

endmodule

// File: rtl/dsp_chain_scheduler.sv
// dsp_chain_scheduler
//   Arbitrates multiply/MAC chains from two requesters onto one DSP slice.
//   clk, rst            : clock, async active-high reset
//   req_*               : per-requester beat interface (valid/ready/first/last,
//                         header mode/shift/c on first beat, operands a/b)
//   rsp_valid/id/data   : one result pulse per chain, tagged with owner
//   err                 : sticky illegal-mode / overlong-chain flag
//   dsp_*               : DSP slice control, operand lane and results
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | wait for a first beat, grant round-robin, latch header
//   S_LOAD  | accept beats of the granted chain into the buffer
//   S_ISSUE | one dsp_start per buffered beat, back to back
//   S_DRAIN | wait for the final compare_res, capture dsp_out
//   S_RESP  | rsp_valid for one cycle
module dsp_chain_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int N     = 9,
  parameter int M     = 9,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_first,
  input  logic [1:0]            req_last,
  input  logic [1:0][1:0]       req_mode,
  input  logic [1:0][1:0]       req_shift,
  input  logic [1:0][N-1:0]     req_a,
  input  logic [1:0][M-1:0]     req_b,
  input  logic [1:0][N+M-1:0]   req_c,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [N+M-1:0]        rsp_data,
  output logic                  err,
  output logic                  dsp_start,
  output logic [1:0]            dsp_mode,
  output logic [N-1:0]          dsp_aa,
  output logic [M-1:0]          dsp_bb,
  output logic [N+M-1:0]        dsp_cc,
  output logic                  dsp_mac,
  output logic [1:0]            dsp_shift,
  input  logic [N+M-1:0]        dsp_out,
  input  logic                  dsp_compare_res
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = N + M;
  localparam int LW = N + M + RW + 1 + 2;

  state_t          state_q, state_d;
  logic            id_q, id_d, rr_q, rr_d;
  logic [1:0]      mode_q, mode_d, shift_q, shift_d;
  logic [RW-1:0]   c_q, c_d, rsp_data_q, rsp_data_d;
  logic [CW-1:0]   cnt_q, cnt_d, rd_q, rd_d, pulse_q, pulse_d;
  logic            done_q, done_d, drop_q, drop_d, err_q, err_d;
  logic            wr_en, issue;

  logic [N-1:0]    a_mem [DEPTH];
  logic [M-1:0]    b_mem [DEPTH];

  logic [1:0]      fv;
  logic            gnt;
  logic [LW-1:0]   lane_in, lane_out;

  assign fv  = req_valid & req_first;
  // rr_q holds the requester that wins a tie.
  assign gnt = (fv[0] & fv[1]) ? rr_q : fv[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      id_q       <= 1'b0;
      rr_q       <= 1'b0;
      mode_q     <= MODE_S;
      shift_q    <= '0;
      c_q        <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      pulse_q    <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      mode_q     <= mode_d;
      shift_q    <= shift_d;
      c_q        <= c_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mem[cnt_q[PW-1:0]] <= req_a[id_q];
      b_mem[cnt_q[PW-1:0]] <= req_b[id_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_d       = rr_q;
    mode_d     = mode_q;
    shift_d    = shift_q;
    c_d        = c_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    pulse_d    = pulse_q;
    done_d     = done_q;
    drop_d     = drop_q;
    err_d      = err_q;
    req_ready  = '0;
    wr_en      = 1'b0;
    issue      = 1'b0;
    rsp_valid  = 1'b0;

    // Tail of an overlong chain is swallowed while the head is processed.
    if (drop_q) begin
      req_ready[id_q] = 1'b1;
      if (req_valid[id_q] && req_last[id_q]) drop_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!drop_q && (fv != 2'b00)) begin
          id_d    = gnt;
          rr_d    = ~gnt;
          mode_d  = req_mode[gnt];
          shift_d = req_shift[gnt];
          c_d     = req_c[gnt];
          cnt_d   = '0;
          rd_d    = '0;
          pulse_d = '0;
          done_d  = 1'b0;
          if (req_mode[gnt] == MODE_X) err_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        req_ready[id_q] = 1'b1;
        if (req_valid[id_q]) begin
          if (mode_q == MODE_X) begin
            if (req_last[id_q]) begin
              rsp_data_d = '0;
              state_d    = S_RESP;
            end
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (req_last[id_q]) begin
              state_d = S_ISSUE;
            end else if (cnt_q == CW'(DEPTH - 1)) begin
              err_d   = 1'b1;
              drop_d  = 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        rd_d  = rd_q + CW'(1);
        if (rd_q == cnt_q - CW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (done_q) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Mode 00 results return during ISSUE, so pulses are counted in both states.
    if ((state_q == S_ISSUE || state_q == S_DRAIN) && dsp_compare_res && !done_q) begin
      pulse_d = pulse_q + CW'(1);
      if (pulse_q + CW'(1) == cnt_q) begin
        done_d     = 1'b1;
        rsp_data_d = dsp_out;
      end
    end
  end

  // Idle lane is all zeros, which gives the DSP its mac=0 gap before beat 0.
  assign lane_in = issue ? {a_mem[rd_q[PW-1:0]], b_mem[rd_q[PW-1:0]], c_q,
                            (cnt_q > CW'(1)), shift_q}
                         : '0;

  dsp_lane_delay #(.W(LW)) u_lane (
    .clk   (clk),
    .rst   (rst),
    .sel_i (lane_dly(mode_q)),
    .d_i   (lane_in),
    .q_o   (lane_out)
  );

  assign {dsp_aa, dsp_bb, dsp_cc, dsp_mac, dsp_shift} = lane_out;
  assign dsp_start = issue;
  assign dsp_mode  = (state_q == S_ISSUE || state_q == S_DRAIN) ? mode_q : MODE_S;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dsp_chain_scheduler.sv
module tb_dsp_chain_scheduler;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [1:0]  mode;
    logic [1:0]  shift;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [17:0] c;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       req_valid, req_ready, req_first, req_last;
  logic [1:0][1:0]  req_mode, req_shift;
  logic [1:0][8:0]  req_a, req_b;
  logic [1:0][17:0] req_c;
  logic             rsp_valid, rsp_id, err, dsp_start, dsp_mac, dsp_compare_res;
  logic [17:0]      rsp_data, dsp_cc, dsp_out;
  logic [1:0]       dsp_mode, dsp_shift;
  logic [8:0]       dsp_aa, dsp_bb;

  always #5 clk = ~clk;

  dsp_chain_scheduler #(.N(9), .M(9), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_first(req_first),
    .req_last(req_last), .req_mode(req_mode), .req_shift(req_shift),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .err(err),
    .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb),
    .dsp_cc(dsp_cc), .dsp_mac(dsp_mac), .dsp_shift(dsp_shift),
    .dsp_out(dsp_out), .dsp_compare_res(dsp_compare_res)
  );

  // DSP slice model: beat after a mac=0 lane cycle adds cc, chained beats add
  // the previous result arithmetically shifted right.
  logic [2:0]         st_sh;
  logic signed [17:0] acc, res, ea, eb, term;
  logic               prev_mac, cr01, lane_v;

  always_comb begin
    lane_v = (dsp_mode == 2'b10) ? st_sh[2] : dsp_start;
    ea     = 18'($signed(dsp_aa));
    eb     = 18'($signed(dsp_bb));
    term   = (dsp_mac && prev_mac) ? (acc >>> dsp_shift) : $signed(dsp_cc);
    res    = ea * eb + term;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_sh <= '0; acc <= '0; prev_mac <= 1'b0; cr01 <= 1'b0;
    end else begin
      st_sh    <= {st_sh[1:0], dsp_start};
      prev_mac <= dsp_mac;
      if (lane_v) acc <= res;
      cr01     <= lane_v && (dsp_mode == 2'b01);
    end
  end

  assign dsp_out         = (dsp_mode == 2'b01) ? acc : res;
  assign dsp_compare_res = (dsp_mode == 2'b01) ? cr01 : lane_v;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  beat_t q0[$];
  beat_t q1[$];
  int    cyc, last_acc, first_start, first_lane, n_start;
  int    r_ids[$];
  int    r_dat[$];
  int    r_cyc[$];

  function automatic beat_t mk(input bit f, input bit l, input int md, input int sh,
                               input int a, input int b, input int c);
    beat_t bt;
    bt.first = f; bt.last = l; bt.mode = 2'(md); bt.shift = 2'(sh);
    bt.a = 9'(a); bt.b = 9'(b); bt.c = 18'(c);
    return bt;
  endfunction

  task automatic add(input int i, input beat_t bt);
    if (i == 0) q0.push_back(bt); else q1.push_back(bt);
  endtask

  task automatic put(input int i, input beat_t bt);
    req_valid[i] = 1'b1; req_first[i] = bt.first; req_last[i] = bt.last;
    req_mode[i]  = bt.mode; req_shift[i] = bt.shift;
    req_a[i] = bt.a; req_b[i] = bt.b; req_c[i] = bt.c;
  endtask

  task automatic drive();
    req_valid = '0; req_first = '0; req_last = '0; req_mode = '0; req_shift = '0;
    req_a = '0; req_b = '0; req_c = '0;
    if (q0.size() > 0) put(0, q0[0]);
    if (q1.size() > 0) put(1, q1[0]);
  endtask

  task automatic clear_obs();
    last_acc = -1; first_start = -1; first_lane = -1; n_start = 0;
    r_ids.delete(); r_dat.delete(); r_cyc.delete();
  endtask

  task automatic step();
    bit hs0, hs1;
    int d;
    @(negedge clk);
    cyc++;
    hs0 = req_valid[0] & req_ready[0];
    hs1 = req_valid[1] & req_ready[1];
    if (hs0 || hs1) last_acc = cyc;
    if (rsp_valid) begin
      d = $signed(rsp_data);
      r_ids.push_back(int'(rsp_id)); r_dat.push_back(d); r_cyc.push_back(cyc);
    end
    if (dsp_start) begin
      n_start++;
      if (first_start < 0) first_start = cyc;
    end
    if (dsp_aa != '0 && first_lane < 0) first_lane = cyc;
    @(posedge clk);
    #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_until(input string tag, input int want, input int maxc);
    int k = 0;
    while (r_dat.size() < want && k < maxc) begin
      step();
      k++;
    end
    check({tag, "_nrsp"}, r_dat.size(), want);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int k;
    cyc = 0;
    clear_obs();
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_dsp_start", int'(dsp_start), 0);
    check("rst_dsp_mode", int'(dsp_mode), 0);
    check("rst_err", int'(err), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_dsp_mac", int'(dsp_mac), 0);
    @(posedge clk); #1;

    // Mode 00 single beat: 3*-2+10
    clear_obs();
    add(0, mk(1, 1, 0, 0, 3, -2, 10));
    drive();
    run_until("m00", 1, 40);
    if (r_dat.size() > 0) begin
      check("m00_id", r_ids[0], 0);
      check("m00_data", r_dat[0], 4);
      check("m00_lat", r_cyc[0] - last_acc, 3);
    end
    check("m00_lag", first_lane - first_start, 0);
    idle(2);

    // Mode 01 three beats: 6, 6+1, 7-4
    clear_obs();
    add(1, mk(1, 0, 1, 0, 2, 3, 0));
    add(1, mk(0, 0, 1, 0, 1, 1, 0));
    add(1, mk(0, 1, 1, 0, 4, -1, 0));
    drive();
    run_until("m01", 1, 60);
    if (r_dat.size() > 0) begin
      check("m01_id", r_ids[0], 1);
      check("m01_data", r_dat[0], 3);
      check("m01_lat", r_cyc[0] - last_acc, 6);
    end
    idle(2);

    // Mode 10 two beats, shift 1: 2*2 + (25>>>1)
    clear_obs();
    add(1, mk(1, 0, 2, 1, 5, 5, 0));
    add(1, mk(0, 1, 2, 1, 2, 2, 0));
    drive();
    run_until("m10", 1, 60);
    if (r_dat.size() > 0) begin
      check("m10_id", r_ids[0], 1);
      check("m10_data", r_dat[0], 16);
      check("m10_lat", r_cyc[0] - last_acc, 7);
    end
    check("m10_lag", first_lane - first_start, 3);
    idle(2);

    // Simultaneous first beats, two chains each: expect 0,1,0,1
    clear_obs();
    add(0, mk(1, 1, 0, 0, 2, 3, 1));
    add(0, mk(1, 1, 0, 0, -1, 4, 0));
    add(1, mk(1, 1, 0, 0, 5, 2, 1));
    add(1, mk(1, 0, 1, 0, 3, 3, -10));
    add(1, mk(0, 1, 1, 0, 1, 2, 0));
    drive();
    run_until("arb", 4, 200);
    if (r_dat.size() >= 4) begin
      check("arb_id0", r_ids[0], 0); check("arb_d0", r_dat[0], 7);
      check("arb_id1", r_ids[1], 1); check("arb_d1", r_dat[1], 11);
      check("arb_id2", r_ids[2], 0); check("arb_d2", r_dat[2], -4);
      check("arb_id3", r_ids[3], 1); check("arb_d3", r_dat[3], 1);
    end
    check("arb_err", int'(err), 0);
    idle(2);

    // Overlong chain: 10 beats, only 1..8 accumulate
    clear_obs();
    for (int i = 1; i <= 10; i++) add(0, mk(i == 1, i == 10, 1, 0, i, 1, 0));
    drive();
    run_until("ovl", 1, 120);
    idle(20);
    check("ovl_nrsp_final", r_dat.size(), 1);
    if (r_dat.size() > 0) check("ovl_data", r_dat[0], 36);
    check("ovl_err", int'(err), 1);
    check("ovl_starts", n_start, 8);
    check("ovl_drop", q0.size(), 0);

    // Reset while issuing
    clear_obs();
    for (int i = 1; i <= 4; i++) add(0, mk(i == 1, i == 4, 0, 0, 1, 1, 0));
    drive();
    k = 0;
    while (n_start == 0 && k < 50) begin
      step();
      k++;
    end
    check("mrst_started", int'(n_start > 0), 1);
    rst = 1'b1;
    #1;
    check("mrst_dsp_start", int'(dsp_start), 0);
    check("mrst_dsp_mode", int'(dsp_mode), 0);
    check("mrst_dsp_aa", int'(dsp_aa), 0);
    check("mrst_req_ready", int'(req_ready), 0);
    check("mrst_err", int'(err), 0);
    q0.delete(); q1.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_obs();
    idle(20);
    check("mrst_no_rsp", r_dat.size(), 0);

    // Chain after reset: mode 00 two beats 16, then 1+16
    clear_obs();
    add(0, mk(1, 0, 0, 0, 4, 4, 0));
    add(0, mk(0, 1, 0, 0, 1, 1, 0));
    drive();
    run_until("post", 1, 60);
    if (r_dat.size() > 0) begin
      check("post_id", r_ids[0], 0);
      check("post_data", r_dat[0], 17);
    end
    check("post_err", int'(err), 0);
    idle(2);

    // Illegal mode: consumed, zero result, no DSP activity
    clear_obs();
    add(1, mk(1, 0, 3, 0, 1, 1, 5));
    add(1, mk(0, 1, 3, 0, 2, 2, 0));
    drive();
    run_until("m11", 1, 60);
    if (r_dat.size() > 0) begin
      check("m11_id", r_ids[0], 1);
      check("m11_data", r_dat[0], 0);
    end
    check("m11_err", int'(err), 1);
    check("m11_starts", n_start, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsp_chain_scheduler.md
# dsp_chain_scheduler

Schedules multiply/MAC chains from two requesters onto one shared DSP slice (clk/start/mode/aa/bb/cc/mac/barrel_shifter/out/compare_res interface). It arbitrates round-robin per chain, buffers a chain's operands, then issues them on consecutive cycles with per-mode operand alignment. It returns one accumulated result per chain to the owning requester. Sits between the requester-side datapath and the DSP slice.

## Interface
- N, 9, width of operand a
- M, 9, width of operand b
- DEPTH, 8, max beats per chain (operand buffer depth, power of 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester beat valid
- req_ready  out  2  per-requester beat accept
- req_first  in  2  beat is first of a chain (carries chain header)
- req_last  in  2  beat is last of a chain
- req_mode  in  2x2  DSP mode (00, 01, 10; 11 illegal), sampled on first beat
- req_shift  in  2x2  barrel_shifter value, sampled on first beat
- req_a  in  2xN  operand a
- req_b  in  2xM  operand b
- req_c  in  2x(N+M)  addend, sampled on first beat only
- rsp_valid  out  1  chain result valid, one-cycle pulse
- rsp_id  out  1  owning requester
- rsp_data  out  N+M  accumulated result (signed)
- err  out  1  sticky: illegal mode or overlong chain
- dsp_start, dsp_mode, dsp_aa, dsp_bb, dsp_cc, dsp_mac, dsp_shift  out  to DSP slice
- dsp_out  in  N+M ; dsp_compare_res  in  1  from DSP slice

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, RESP.
- IDLE: if any req_valid with req_first, grant round-robin (last-granted loses ties); latch id, mode, shift, c; go LOAD. req_ready=0 in IDLE.
- LOAD: req_ready[id]=1; each accepted beat writes (a,b) to buffer at wr_ptr. On accepted req_last, or at DEPTH beats, go ISSUE. DEPTH beats without req_last: set err, treat beat DEPTH as last, drop following beats until req_last (ready held 1).
- Mode 11 at first beat: set err, consume chain to req_last, return rsp_data=0, no DSP issue.
- ISSUE: dsp_start=1 for exactly count consecutive cycles, one beat per cycle, no bubbles. Operand lane (aa, bb, cc, mac, shift) delayed by L cycles behind dsp_start: L=3 for mode 10, L=0 otherwise.
- dsp_mac on lane: 0 in cycle before beat 0 (guaranteed gap), 1 for all beats when count>1; count==1 gives mac=0. Beat 0 adds c; later beats add out shifted right by shift (sign-extended).
- dsp_mode held at chain mode from ISSUE until exit DRAIN; otherwise 00 with dsp_start=0.
- DRAIN: count compare_res pulses; capture dsp_out on last one into rsp_data; go RESP.
- RESP: rsp_valid=1 one cycle; go IDLE. Next grant no earlier than cycle after RESP.

## Timing
- Reset: all outputs 0, state IDLE, round-robin pointer to requester 0, err 0.
- Result timing vs dsp_start of beat k at cycle t: compare_res at t (mode 00), t+1 (01), t+3 (10).
- Chain latency from last accepted beat to rsp_valid: count+1+{0,1,3}+1 cycles.
- Mid-chain reset: abort immediately, drop buffer, no rsp.
- Simultaneous first beats: grant alternates; the loser's req_ready stays 0 (beat held by requester).

## Structure
- Package dsp_sched_pkg: state enum, mode constants (MODE_S=00, MODE_M=01, MODE_F=10), latency function lat(mode).
- Sub-module dsp_lane_delay: parameterized 0..3 cycle shift register for the operand lane, depth selected by mode.

## Test plan
- Mode 00, req0 single beat a=3, b=-2, c=10 -> rsp_valid, rsp_id=0, rsp_data=4.
- Mode 01, req1 chain of 3 beats (2,3),(1,1),(4,-1), shift=0, c=0 -> rsp_data=3.
- Mode 10, 2 beats (5,5),(2,2), shift=1, c=0 -> lane lags start by 3; rsp_data=4+12=16.
- Both requesters post first beats same cycle, twice -> grants 0,1,0,1 order; responses carry matching rsp_id.
- Chain of DEPTH+2 beats -> err=1, buffer holds first DEPTH, extra beats dropped, one rsp.
- Assert rst during ISSUE -> all outputs 0 next cycle, no rsp_valid, next chain correct.
